// File: rtl/max_reduce_issuer.sv
// MAX reduction-chain issuer: turns one pooling job (register window + destination)
// into a serial chain of 12-bit MAX instructions for the max-pool decoder, inserting
// HAZARD_GAP idle cycles after each accepted instruction because every instruction
// after the first reads the destination written by the previous one.
module max_reduce_issuer #(
   parameter int unsigned HAZARD_GAP = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [3:0]  base_reg_i,
   input  logic [4:0]  num_regs_i,
   input  logic [3:0]  dst_reg_i,
   output logic [11:0] inst_o,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   localparam int unsigned GapW = (HAZARD_GAP > 1) ? $clog2(HAZARD_GAP + 1) : 1;
   // Gap counter load value: counts down to zero, so a load of N-1 gives N idle cycles.
   localparam logic [GapW-1:0] GapLoad = GapW'((HAZARD_GAP > 0) ? HAZARD_GAP - 1 : 0);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StGap,
      StDone
   } state_e;

   state_e          state_q, state_d;
   logic [3:0]      base_q, base_d;
   logic [4:0]      num_q, num_d;
   logic [3:0]      dst_q, dst_d;
   logic [3:0]      k_q, k_d;
   logic [GapW-1:0] gap_q, gap_d;
   logic [11:0]     inst_q, inst_d;
   logic            err_q, err_d;

   logic            start_ok;
   logic            handshake;
   logic [3:0]      last_k;
   logic            is_last;
   logic [3:0]      k_inc;

   // Instruction k of the chain: the first pairs the two lowest window registers,
   // later ones fold the running maximum (held in dst) with the next window register.
   function automatic logic [11:0] make_inst(input logic [3:0] base, input logic [4:0] num,
                                             input logic [3:0] dst, input logic [3:0] k);
      logic [3:0] src1;
      logic [3:0] src2;
      if (k == 4'd0) begin
         src1 = base;
         src2 = (num == 5'd1) ? base : 4'(base + 4'd1);
      end else begin
         src1 = dst;
         src2 = 4'(base + k + 4'd1);
      end
      return {src1, src2, dst};
   endfunction

   // Job decode: legality of a new request and position within the current chain.
   always_comb begin
      start_ok  = start_i && (num_regs_i != 5'd0) && (num_regs_i <= 5'd16);
      handshake = (state_q == StIssue) && inst_ready_i;
      // Chain length is max(num-1, 1), so the last index is max(num-2, 0).
      last_k    = (num_q <= 5'd2) ? 4'd0 : 4'(num_q - 5'd2);
      is_last   = (k_q == last_k);
      k_inc     = 4'(k_q + 4'd1);
   end

   // Next-state logic for the issue FSM and the latched job.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      num_d   = num_q;
      dst_d   = dst_q;
      k_d     = k_q;
      gap_d   = gap_q;
      inst_d  = inst_q;
      err_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               base_d  = base_reg_i;
               num_d   = num_regs_i;
               dst_d   = dst_reg_i;
               k_d     = 4'd0;
               inst_d  = make_inst(base_reg_i, num_regs_i, dst_reg_i, 4'd0);
               state_d = StIssue;
            end else if (start_i) begin
               err_d = 1'b1;
            end
         end
         StIssue: begin
            // Abort wins even over a simultaneous handshake: no done is produced.
            if (abort_i) begin
               state_d = StIdle;
               k_d     = 4'd0;
            end else if (handshake) begin
               if (is_last) begin
                  state_d = StDone;
               end else begin
                  k_d = k_inc;
                  if (HAZARD_GAP > 0) begin
                     gap_d   = GapLoad;
                     state_d = StGap;
                  end else begin
                     inst_d = make_inst(base_q, num_q, dst_q, k_inc);
                  end
               end
            end
         end
         StGap: begin
            if (abort_i) begin
               state_d = StIdle;
               k_d     = 4'd0;
            end else if (gap_q == '0) begin
               inst_d  = make_inst(base_q, num_q, dst_q, k_q);
               state_d = StIssue;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         StDone: begin
            // A start seen here is dropped; IDLE accepts from the next cycle.
            state_d = StIdle;
            k_d     = 4'd0;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and job registers; reset abandons any in-flight job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         base_q  <= 4'd0;
         num_q   <= 5'd0;
         dst_q   <= 4'd0;
         k_q     <= 4'd0;
         gap_q   <= '0;
         inst_q  <= 12'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         num_q   <= num_d;
         dst_q   <= dst_d;
         k_q     <= k_d;
         gap_q   <= gap_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
      end
   end

   // Outputs are decoded from registered state only.
   always_comb begin
      inst_o       = inst_q;
      inst_valid_o = (state_q == StIssue);
      busy_o       = (state_q == StIssue) || (state_q == StGap);
      done_o       = (state_q == StDone);
      err_o        = err_q;
   end

   // A presented instruction must not change or retract while the decoder stalls.
   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (inst_valid_o && !inst_ready_i && !abort_i) |=> (inst_valid_o && $stable(inst_o)));

   // An illegal request never starts a job.
   a_err_idle: assert property (@(posedge clk) disable iff (!rst_n)
      err_o |-> !busy_o);

endmodule

// File: tb/tb_max_reduce_issuer.sv
// Bench for max_reduce_issuer: two instances (HAZARD_GAP=2 and 0) share stimulus;
// each has its own reference queue fed on accepted starts and drained by a monitor.
module tb_max_reduce_issuer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  base = 4'd0;
   logic [4:0]  num = 5'd0;
   logic [3:0]  dst = 4'd0;
   logic        ready = 1'b1;
   int          ready_mode = 0;

   logic [11:0] inst_w [2];
   logic [1:0]  valid_w, busy_w, done_w, err_w;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected instruction i of a job, straight from the reduction-chain rules.
   function automatic logic [11:0] ref_inst(input int b, input int n, input int d, input int i);
      int s1, s2;
      s1 = (i == 0) ? b : d;
      if (n == 1) s2 = b;
      else        s2 = (b + i + 1) % 16;
      return {4'(s1), 4'(s2), 4'(d)};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned Gap = (g == 0) ? 2 : 0;

      max_reduce_issuer #(.HAZARD_GAP(Gap)) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .start_i     (start),
         .abort_i     (abort),
         .base_reg_i  (base),
         .num_regs_i  (num),
         .dst_reg_i   (dst),
         .inst_o      (inst_w[g]),
         .inst_valid_o(valid_w[g]),
         .inst_ready_i(ready),
         .busy_o      (busy_w[g]),
         .done_o      (done_w[g]),
         .err_o       (err_w[g])
      );

      logic [11:0] exp_q[$];
      bit          active = 0;
      bit          done_now = 0;
      bit          err_now = 0;
      bit          hold_chk = 0;
      int          gap_left = -1;
      logic [11:0] hold_inst = 12'd0;

      // Monitor: checks what the DUT shows now, then applies the upcoming edge's events.
      always @(negedge clk) begin
         bit done_nx;
         bit err_nx;
         int n_inst;
         logic [11:0] e;
         if (!rst_n) begin
            exp_q.delete();
            active   = 0;
            done_now = 0;
            err_now  = 0;
            hold_chk = 0;
            gap_left = -1;
         end else begin
            chk($sformatf("g%0d_busy", g), busy_w[g], active);
            chk($sformatf("g%0d_done", g), done_w[g], done_now);
            chk($sformatf("g%0d_err", g), err_w[g], err_now);
            if (!active) begin
               chk($sformatf("g%0d_valid_idle", g), valid_w[g], 0);
            end else if (gap_left > 0) begin
               chk($sformatf("g%0d_gap_low", g), valid_w[g], 0);
               gap_left--;
            end else if (gap_left == 0) begin
               chk($sformatf("g%0d_valid_rise", g), valid_w[g], 1);
               gap_left = -1;
            end
            if (hold_chk) begin
               chk($sformatf("g%0d_hold_valid", g), valid_w[g], 1);
               chk($sformatf("g%0d_hold_inst", g), inst_w[g], hold_inst);
            end
            hold_chk = 0;
            done_nx  = 0;
            err_nx   = 0;
            if (!active && !done_now && start) begin
               if (num >= 1 && num <= 16) begin
                  n_inst = (num == 1) ? 1 : int'(num) - 1;
                  for (int i = 0; i < n_inst; i++)
                     exp_q.push_back(ref_inst(int'(base), int'(num), int'(dst), i));
                  active   = 1;
                  gap_left = 0;
               end else begin
                  err_nx = 1;
               end
            end else if (active) begin
               if (valid_w[g] && ready) begin
                  if (exp_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL g%0d_extra_inst: got %0h want none", g, inst_w[g]);
                  end else begin
                     e = exp_q.pop_front();
                     chk($sformatf("g%0d_inst", g), inst_w[g], e);
                  end
                  if (exp_q.size() == 0 && !abort) begin
                     done_nx = 1;
                     active  = 0;
                  end else if (!abort) begin
                     gap_left = int'(Gap);
                  end
               end else if (valid_w[g] && !abort) begin
                  hold_chk  = 1;
                  hold_inst = inst_w[g];
               end
               if (abort) begin
                  exp_q.delete();
                  active   = 0;
                  gap_left = -1;
               end
            end
            done_now = done_nx;
            err_now  = err_nx;
         end
      end
   end

   // Ready generator: 0 = always ready, 1 = random stalls, 2 = held low.
   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       ready = 1'b1;
         1:       ready = ($urandom_range(0, 3) != 0);
         default: ready = 1'b0;
      endcase
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((busy_w != 2'b00 || done_w != 2'b00) && t < 600) begin
         cyc(1);
         t++;
      end
      if (t >= 600) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got busy=%b want 00", busy_w);
      end
   endtask

   // One job request; abort_at > 0 raises abort that many cycles after the start.
   task automatic job(input int b, input int n, input int d, input int abort_at);
      wait_idle();
      start = 1'b1;
      base  = 4'(b);
      num   = 5'(n);
      dst   = 4'(d);
      cyc(1);
      start = 1'b0;
      if (abort_at > 0) begin
         cyc(abort_at);
         abort = 1'b1;
         cyc(1);
         abort = 1'b0;
      end
      cyc(1);
      wait_idle();
   endtask

   task automatic chk_all_zero(input string nm);
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("%s_inst%0d", nm, g), inst_w[g], 0);
         chk($sformatf("%s_valid%0d", nm, g), valid_w[g], 0);
         chk($sformatf("%s_busy%0d", nm, g), busy_w[g], 0);
         chk($sformatf("%s_done%0d", nm, g), done_w[g], 0);
         chk($sformatf("%s_err%0d", nm, g), err_w[g], 0);
      end
   endtask

   initial begin
      cyc(2);
      chk_all_zero("reset");
      rst_n = 1'b1;
      cyc(2);

      // Directed chains with ready tied high.
      job(2, 4, 9, 0);
      job(7, 1, 0, 0);
      job(14, 4, 1, 0);
      job(0, 16, 3, 0);

      // Decoder stalls five cycles on the second instruction.
      wait_idle();
      start = 1'b1; base = 4'd2; num = 5'd4; dst = 4'd9;
      cyc(1);
      start = 1'b0;
      cyc(2);
      ready_mode = 2;
      cyc(6);
      ready_mode = 0;
      wait_idle();

      // Illegal window sizes.
      job(3, 0, 5, 0);
      job(3, 17, 5, 0);
      job(0, 31, 0, 0);

      // Start while busy must not disturb the latched job.
      wait_idle();
      start = 1'b1; base = 4'd1; num = 5'd8; dst = 4'd2;
      cyc(1);
      start = 1'b0;
      cyc(2);
      start = 1'b1; base = 4'd5; num = 5'd3; dst = 4'd7;
      cyc(1);
      start = 1'b0;
      wait_idle();

      // Asynchronous reset while the gap-2 instance sits in its gap.
      start = 1'b1; base = 4'd2; num = 5'd6; dst = 4'd4;
      cyc(1);
      start = 1'b0;
      cyc(1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      cyc(1);
      rst_n = 1'b1;
      cyc(2);

      // Abort mid-job, then a fresh job starting from the first instruction.
      job(4, 10, 6, 2);
      job(4, 10, 6, 0);
      job(9, 5, 9, 1);

      // Randomized jobs with random stalls and occasional aborts.
      ready_mode = 1;
      for (int j = 0; j < 40; j++) begin
         job(int'($urandom_range(0, 15)), int'($urandom_range(0, 18)),
             int'($urandom_range(0, 15)),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : 0);
      end
      ready_mode = 0;
      job(0, 16, 3, 0);
      cyc(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
